// File: rtl/mmio_pkg.sv
// Shared constants and types for the load read-select / MMIO path.
package mmio_pkg;

  // Address regions, decoded from addr[31:28]
  localparam logic [3:0] REGION_BIOS = 4'h4;
  localparam logic [3:0] REGION_MMIO = 4'h8;

  // MMIO register byte offsets (word aligned, taken from addr[7:0])
  localparam logic [7:0] OFF_STATUS   = 8'h00;
  localparam logic [7:0] OFF_RX       = 8'h04;
  localparam logic [7:0] OFF_TX       = 8'h08;
  localparam logic [7:0] OFF_CNT_CLR  = 8'h0C;
  localparam logic [7:0] OFF_CNT_BASE = 8'h40;

  // Registered source selection for the load data mux
  typedef enum logic [1:0] {
    SEL_DMEM = 2'd0,
    SEL_BIOS = 2'd1,
    SEL_MMIO = 2'd2
  } rsel_e;

  // Map the top address nibble to a load source; everything unknown is DMEM
  function automatic rsel_e decode_region(input logic [3:0] region);
    rsel_e sel;
    sel = SEL_DMEM;
    if (region == REGION_BIOS) sel = SEL_BIOS;
    else if (region == REGION_MMIO) sel = SEL_MMIO;
    return sel;
  endfunction

endpackage

// File: rtl/mmio_rx_fifo.sv
// Byte FIFO buffering UART RX data; head byte is visible combinationally.
module mmio_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW-1:0] wr_ptr_d, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot this cycle
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_q];
  assign count   = count_q;

  // Pointer/occupancy next state; pointers wrap naturally at power-of-two depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  // Storage array; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_rsel_buf.sv
// Memory-stage load read-select across BIOS, DMEM and an MMIO block holding
// a UART RX FIFO, a UART TX holding register and software-clearable counters.
module mmio_rsel_buf
  import mmio_pkg::*;
#(
  parameter int RX_DEPTH   = 8,
  parameter int N_COUNTERS = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           addr,
  input  logic                  re,
  input  logic                  we,
  input  logic [31:0]           wdata,
  input  logic [31:0]           bios_doutb,
  input  logic [31:0]           dmem_douta,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  input  logic [N_COUNTERS-1:0] event_in,
  output logic [31:0]           dout
);

  localparam int CW = $clog2(RX_DEPTH) + 1;

  rsel_e                       sel_q, sel_d;
  logic [31:0]                 mmio_rdata_q, mmio_rdata_d;
  logic                        tx_valid_q, tx_valid_d;
  logic [7:0]                  tx_data_q, tx_data_d;
  logic [N_COUNTERS*CNT_W-1:0] cnt_flat;

  logic [7:0]    off;
  logic          is_mmio, cnt_hit;
  logic [3:0]    cnt_idx;
  logic          rd_rx, wr_tx, wr_clr;
  logic          fifo_push, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [7:0]    occupancy;
  logic          unused_ok;

  assign off       = {addr[7:2], 2'b00};
  assign is_mmio   = (addr[31:28] == REGION_MMIO);
  assign cnt_hit   = (off[7:6] == OFF_CNT_BASE[7:6]);
  assign cnt_idx   = off[5:2];
  assign rd_rx     = re & is_mmio & (off == OFF_RX);
  assign wr_tx     = we & is_mmio & (off == OFF_TX);
  assign wr_clr    = we & is_mmio & (off == OFF_CNT_CLR);
  assign rx_ready  = ~fifo_full;
  assign fifo_push = rx_valid & rx_ready;
  assign occupancy = 8'(fifo_count);
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign unused_ok = ^{addr[27:8], addr[1:0], wdata[31:8]};

  mmio_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (rx_data),
    .pop   (rd_rx),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Event counters: clear wins over a coincident event, increments wrap
  for (genvar gi = 0; gi < N_COUNTERS; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter next state
    always_comb begin
      cnt_d = cnt_q;
      if (wr_clr) cnt_d = '0;
      else if (event_in[gi]) cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_q;
  end

  // Select tracking and MMIO read data; both only move on a load
  always_comb begin
    sel_d        = re ? decode_region(addr[31:28]) : sel_q;
    mmio_rdata_d = mmio_rdata_q;
    if (re && is_mmio) begin
      mmio_rdata_d = '0;
      if (off == OFF_STATUS) begin
        mmio_rdata_d = {16'b0, occupancy, 6'b0, ~fifo_empty, ~tx_valid_q};
      end else if (off == OFF_RX) begin
        mmio_rdata_d = fifo_empty ? 32'h0 : {24'b0, fifo_dout};
      end else if (cnt_hit) begin
        for (int i = 0; i < N_COUNTERS; i++) begin
          if (cnt_idx == 4'(i)) mmio_rdata_d = 32'(cnt_flat[i*CNT_W +: CNT_W]);
        end
      end
    end
  end

  // TX holding register: load only when idle, drop on accepted handshake
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (tx_valid_q) begin
      if (tx_ready) tx_valid_d = 1'b0;
    end else if (wr_tx) begin
      tx_valid_d = 1'b1;
      tx_data_d  = wdata[7:0];
    end
  end

  // Select, MMIO read data and TX state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q        <= SEL_DMEM;
      mmio_rdata_q <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      sel_q        <= sel_d;
      mmio_rdata_q <= mmio_rdata_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
    end
  end

  // Load data mux, aligned with the synchronous BIOS/DMEM read latency
  always_comb begin
    case (sel_q)
      SEL_BIOS: dout = bios_doutb;
      SEL_MMIO: dout = mmio_rdata_q;
      default:  dout = dmem_douta;
    endcase
  end

endmodule

// File: tb/tb_mmio_rsel_buf.sv
// Directed bench for mmio_rsel_buf: loads push expected dout into a
// scoreboard queue, a monitor pops and compares one cycle after each load.
module tb_mmio_rsel_buf;

  localparam logic [31:0] A_STATUS = 32'h8000_0000;
  localparam logic [31:0] A_RX     = 32'h8000_0004;
  localparam logic [31:0] A_TX     = 32'h8000_0008;
  localparam logic [31:0] A_CLR    = 32'h8000_000C;
  localparam logic [31:0] A_CNT0   = 32'h8000_0040;
  localparam logic [31:0] A_CNT1   = 32'h8000_0044;
  localparam logic [31:0] A_CNT2   = 32'h8000_0048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata, bios_doutb, dmem_douta, dout;
  logic        re, we, rx_valid, rx_ready, tx_valid, tx_ready;
  logic [7:0]  rx_data, tx_data;
  logic [3:0]  event_in;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          tx_xfers = 0;
  logic [7:0]  tx_last = 8'h00;

  always #5 clk = ~clk;

  mmio_rsel_buf #(.RX_DEPTH(8), .N_COUNTERS(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .re         (re),
    .we         (we),
    .wdata      (wdata),
    .bios_doutb (bios_doutb),
    .dmem_douta (dmem_douta),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .event_in   (event_in),
    .dout       (dout)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end else begin
      $display("ok   %s got=%h", nm, act);
    end
  endtask

  // All stimulus tasks start and end on a negative clock edge
  task automatic load(input logic [31:0] a, input logic [31:0] exp, input string nm);
    exp_t e;
    e.name = nm;
    e.exp  = exp;
    sb_q.push_back(e);
    addr = a;
    re   = 1'b1;
    @(negedge clk);
    re   = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Scoreboard monitor: a load captured at this edge shows on dout right after
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (re && rst_n) begin
        #1;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow dout=%h expected no load", dout);
        end else begin
          e = sb_q.pop_front();
          if (dout !== e.exp) begin
            errors++;
            $display("FAIL %s dout=%h expected=%h", e.name, dout, e.exp);
          end else begin
            $display("ok   %s dout=%h", e.name, dout);
          end
        end
      end
    end
  end

  // Count accepted TX handshakes
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && tx_valid && tx_ready) begin
        tx_xfers++;
        tx_last = tx_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; addr = '0; re = 1'b0; we = 1'b0; wdata = '0;
    bios_doutb = 32'hDEAD_BEEF; dmem_douta = 32'hCAFE_0001;
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0; event_in = '0;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'h1);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_dout_dmem", dout, 32'hCAFE_0001);
    rst_n = 1'b1;
    @(negedge clk);

    // BIOS and DMEM steering
    load(32'h4000_0010, 32'hDEAD_BEEF, "bios_load");
    dmem_douta = 32'h1234_5678;
    load(32'h1000_0000, 32'h1234_5678, "dmem_load");

    // RX FIFO ordering and empty read
    push_rx(8'h41); push_rx(8'h42); push_rx(8'h43);
    load(A_STATUS, 32'h0000_0303, "status_3");
    load(A_RX, 32'h41, "rx_0");
    load(A_RX, 32'h42, "rx_1");
    load(A_RX, 32'h43, "rx_2");
    load(A_RX, 32'h0, "rx_empty");
    load(A_STATUS, 32'h0000_0001, "status_empty");

    // Full FIFO: push refused in the same cycle as a pop
    for (int i = 0; i < 8; i++) push_rx(8'(8'h10 + i));
    check("full_rx_ready", 32'(rx_ready), 32'h0);
    rx_data  = 8'h99;
    rx_valid = 1'b1;
    load(A_RX, 32'h10, "rx_pop_full");
    check("after_pop_rx_ready", 32'(rx_ready), 32'h1);
    @(negedge clk);
    rx_valid = 1'b0;
    check("refill_rx_ready", 32'(rx_ready), 32'h0);
    load(A_STATUS, 32'h0000_0803, "status_8");
    for (int i = 0; i < 7; i++) load(A_RX, 32'h11 + 32'(i), "rx_drain");
    load(A_RX, 32'h99, "rx_drain_99");
    load(A_STATUS, 32'h0000_0001, "status_drained");

    // TX handshake
    store(A_TX, 32'h0000_0055);
    check("tx_valid_set", 32'(tx_valid), 32'h1);
    check("tx_data_55", 32'(tx_data), 32'h55);
    load(A_STATUS, 32'h0000_0000, "status_tx_busy");
    store(A_TX, 32'h0000_0066);
    check("tx_data_hold", 32'(tx_data), 32'h55);
    tx_ready = 1'b1;
    store(A_TX, 32'h0000_0077);
    tx_ready = 1'b0;
    check("tx_valid_clr", 32'(tx_valid), 32'h0);
    @(negedge clk);
    check("tx_xfers", 32'(tx_xfers), 32'h1);
    check("tx_last", 32'(tx_last), 32'h55);

    // Counters: wrap, unmapped, pre-increment read, clear vs event
    store(A_CLR, 32'h0);
    event_in = 4'b0010;
    repeat (17) @(negedge clk);
    event_in = 4'b0000;
    load(A_CNT1, 32'h1, "cnt1_wrap");
    load(A_CNT0, 32'h0, "cnt0_idle");
    load(32'h8000_0050, 32'h0, "cnt4_unmapped");
    load(32'h8000_0020, 32'h0, "mmio_unmapped");
    event_in = 4'b0001;
    repeat (5) @(negedge clk);
    load(A_CNT0, 32'h5, "cnt0_pre_inc");
    store(A_CLR, 32'hFFFF_FFFF);
    event_in = 4'b0000;
    load(A_CNT0, 32'h0, "cnt0_clr_event");
    load(A_CNT1, 32'h0, "cnt1_cleared");

    // Reset in the middle of FIFO and TX activity
    store(A_TX, 32'h0000_00AB);
    check("tx_valid_pre_rst", 32'(tx_valid), 32'h1);
    push_rx(8'hA1); push_rx(8'hA2); push_rx(8'hA3);
    event_in = 4'b0100;
    repeat (3) @(negedge clk);
    event_in = 4'b0000;
    load(A_CNT2, 32'h3, "cnt2_pre_rst");
    load(32'h4000_0000, 32'hDEAD_BEEF, "bios_pre_rst");
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rx_ready", 32'(rx_ready), 32'h1);
    check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
    check("mid_rst_tx_data", 32'(tx_data), 32'h0);
    check("mid_rst_dout", dout, 32'h1234_5678);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load(A_STATUS, 32'h0000_0001, "status_post_rst");
    load(A_RX, 32'h0, "rx_post_rst");
    load(A_CNT2, 32'h0, "cnt2_post_rst");

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_rsel_buf.md
Name: mmio_rsel_buf

Overview:
- Parametrised successor to the core's data-memory read-select path.
- Steers loads between BIOS, DMEM and a memory-mapped I/O region.
- The MMIO region adds a buffered UART RX FIFO, a handshaked UART TX holding register, and N generic event counters with software clear.
- MMIO read data is registered so it aligns with the 1-cycle synchronous BIOS/DMEM reads in the memory stage.

Parameters:
- RX_DEPTH, 8, RX FIFO entries; power of two, minimum 2.
- N_COUNTERS, 4, number of event counters; 1..16.
- CNT_W, 32, counter width; 1..32, zero-extended on read.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  32  load/store byte address (execute stage, same cycle as memory enables)
- re  in  1  load strobe
- we  in  1  store strobe
- wdata  in  32  store data
- bios_doutb  in  32  BIOS read data (valid the cycle after the address)
- dmem_douta  in  32  DMEM read data (valid the cycle after the address)
- rx_valid  in  1  UART receiver byte valid
- rx_data  in  8  UART receiver byte
- rx_ready  out  1  FIFO can accept a byte
- tx_valid  out  1  TX byte pending
- tx_data  out  8  TX byte
- tx_ready  in  1  UART transmitter accepts the byte
- event_in  in  N_COUNTERS  per-counter increment enables
- dout  out  32  load data, 1 cycle after re

Behaviour:
- Region decode on addr[31:28]:
  - 4'h4 selects BIOS.
  - 4'h8 selects MMIO.
  - Any other value selects DMEM.
- The region select is registered on every cycle with re=1; dout muxes bios_doutb, dmem_douta or the registered MMIO data using that registered select.
- MMIO offsets (addr[7:2] word index):
  - 0x00 STATUS (read): {16'b0, occupancy[7:0], 6'b0, rx_nonempty, ~tx_valid}.
  - 0x04 RX_DATA (read): {24'b0, head byte} and pops the FIFO. When the FIFO is empty it returns 0 and does not pop.
  - 0x08 TX_DATA (write): when tx_valid=0, loads wdata[7:0] and sets tx_valid. When tx_valid=1 the write is ignored and the byte is dropped.
  - 0x0C CNT_CLR (write): any value clears all counters.
  - 0x40+4*i CNT_i (read), for i < N_COUNTERS: zero-extended counter i.
  - Unmapped MMIO reads return 0. Unmapped writes have no effect.
- Stores never alter dout.
- A load with re=0 has no side effects and leaves dout undefined-but-stable (it holds its last mux output).
- TX handshake: tx_valid/tx_data hold until a cycle with tx_valid & tx_ready, then tx_valid clears on the next edge. A TX_DATA write in that same cycle is ignored.
- RX FIFO:
  - rx_ready = ~full, combinational from the current count.
  - Push on rx_valid & rx_ready.
  - Pop on a RX_DATA read when nonempty.
  - Simultaneous push and pop: occupancy unchanged and the data order is preserved.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Pointers wrap modulo RX_DEPTH.
  - Occupancy saturates in its 8-bit field; RX_DEPTH ≤ 128 is required.
- Counters:
  - Counter i increments by 1 on each cycle with event_in[i]=1.
  - Counters wrap from 2^CNT_W-1 to 0.
  - CNT_CLR in the same cycle as an event: the counter becomes 0.
  - A counter read returns the value before that cycle's increment.
- Reset: all of the following go to 0 asynchronously, and the system must release reset synchronously to clk:
  - rx_ready goes to 1, since the FIFO is empty.
  - tx_valid, tx_data, the counters, the FIFO pointers, the registered select and the MMIO data.
  - dout, which outputs the DMEM path (dmem_douta).
  - Any in-flight TX byte is lost.

Decomposition:
- Package mmio_pkg holds:
  - Region codes REGION_BIOS=4'h4 and REGION_MMIO=4'h8.
  - Offsets OFF_STATUS, OFF_RX, OFF_TX, OFF_CNT_CLR and OFF_CNT_BASE=8'h40.
  - A 2-bit region-select enum.
- One sub-module, mmio_rx_fifo (parameter DEPTH), provides:
  - Ports clk, rst_n, push, din, pop, dout, full, empty, count.

Test Plan:
- Reset, then a load at 0x4000_0010 with bios_doutb=0xDEAD_BEEF → dout=0xDEAD_BEEF one cycle later. A load at 0x1000_0000 with dmem_douta=0x1234_5678 → dout=0x1234_5678.
- Push bytes 0x41, 0x42, 0x43 → STATUS reads 0x0000_0303 (tx idle). Three RX_DATA reads return 0x41, 0x42, 0x43. A fourth read returns 0 and STATUS becomes 0x0000_0001.
- RX_DEPTH=8: push 8 bytes → rx_ready=0. Hold rx_valid with 0x99 while issuing a RX_DATA read in the same cycle → the read returns the first byte and 0x99 is not accepted. Next cycle rx_ready=1 and 0x99 is accepted; occupancy reads 8.
- Write 0x55 to TX_DATA with tx_ready=0 → tx_valid=1, tx_data=0x55. Write 0x66 → ignored. Raise tx_ready for 1 cycle → tx_valid=0 the following cycle and the 0x55 transfer is observed once.
- CNT_W=4, event_in[1] held high for 17 cycles after a clear → CNT_1 reads 1 (wrapped). A CNT_CLR coinciding with event_in[0]=1 → CNT_0 reads 0 next cycle.
- Assert rst_n=0 mid-FIFO (3 entries) and mid-TX (tx_valid=1) → immediately rx_ready=1, tx_valid=0, dout=dmem_douta path, and STATUS after release reads 0x0000_0001.
